// File: rtl/clint_pkg.sv
// ============================================================================
// Module   : clint_pkg
// Brief    : Shared types and constants for the core-local trap controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clint_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MSTATUS = 3'd2,
    W_MCAUSE  = 3'd3,
    W_MRET    = 3'd4,
    ASSERT    = 3'd5
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Trap entry stacks MIE into MPIE and disables interrupts.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clint.sv
// ============================================================================
// Module   : clint
// Brief    : Core-local trap controller; sequences mepc/mstatus/mcause writes
//            and redirects to the handler or the mret return address.
//            Optional vectored interrupt targets: CLINT_VECTORED_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] IRQ_CAUSE = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_t      state;
  logic [31:0] epc;
  logic [31:0] cause;
  logic [31:0] target;

  logic        idle;
  logic        take_ecall;
  logic        take_ebreak;
  logic        take_mret;
  logic        take_irq;
  logic        take_trap;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign idle        = (state == IDLE);
  assign take_ecall  = idle & inst_valid_i & ecall_i;
  assign take_ebreak = idle & inst_valid_i & ~ecall_i & ebreak_i;
  assign take_mret   = idle & inst_valid_i & ~ecall_i & ~ebreak_i & mret_i;
  assign take_irq    = idle & inst_valid_i & ~ecall_i & ~ebreak_i & ~mret_i
                     & irq_i & mstatus_i[MSTATUS_MIE];
  assign take_trap   = take_ecall | take_ebreak | take_irq;
  assign trap_base   = {mtvec_i[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  logic unused_cause_bit;
  assign unused_cause_bit = cause[30];
  assign trap_target = (mtvec_i[1:0] == 2'b01 && cause[31])
                     ? trap_base + {cause[29:0], 2'b00}
                     : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign trap_target = trap_base;
`endif

  // Combinational term holds the trapping instruction back from writeback.
  assign stall_o = ~idle | take_trap | take_mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      epc    <= 32'd0;
      cause  <= 32'd0;
      target <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap) begin
            epc   <= inst_addr_i;
            cause <= take_ecall  ? CAUSE_ECALL_M :
                     take_ebreak ? CAUSE_BREAKPOINT : IRQ_CAUSE;
            state <= W_MEPC;
          end else if (take_mret) begin
            state <= W_MRET;
          end
        end
        W_MEPC:    state <= W_MSTATUS;
        W_MSTATUS: state <= W_MCAUSE;
        W_MCAUSE: begin
          target <= trap_target;
          state  <= ASSERT;
        end
        W_MRET: begin
          target <= mepc_i;
          state  <= ASSERT;
        end
        ASSERT:    state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 32'd0;
    csr_wdata_o  = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    case (state)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MEPC};
        csr_wdata_o = epc;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = trap_mstatus(mstatus_i);
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MCAUSE};
        csr_wdata_o = cause;
      end
      W_MRET: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mret_mstatus(mstatus_i);
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = target;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/clint.md
# clint

Core-local trap controller feeding the CSR register file's `clint_*` write port.
- Detects ecall/ebreak, mret and a level-sensitive external interrupt at the execute stage.
- Stalls the pipeline, then writes mepc/mstatus/mcause through a fixed multi-cycle CSR write sequence.
- Finally issues a one-cycle redirect to the trap handler or return address.

## Interface
Parameters:
- IRQ_CAUSE, 32'h8000_000B: mcause value written for the external interrupt.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid_i  in  1  exu holds a valid, not-yet-retired instruction
- inst_addr_i  in  32  PC of that instruction
- ecall_i  in  1  decoded ecall; ignored unless inst_valid_i
- ebreak_i  in  1  decoded ebreak; ignored unless inst_valid_i
- mret_i  in  1  decoded mret; ignored unless inst_valid_i
- irq_i  in  1  external interrupt request, level, held until serviced
- mtvec_i  in  32  current mtvec from the CSR file
- mepc_i  in  32  current mepc from the CSR file
- mstatus_i  in  32  current mstatus from the CSR file
- csr_we_o  out  1  to clint_we_i
- csr_waddr_o  out  32  to clint_waddr_i; upper 20 bits are 0
- csr_wdata_o  out  32  to clint_wdata_i
- stall_o  out  1  hold fetch/decode; suppress exu writeback and exu CSR writes
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target, valid with int_assert_o

## Operation
- FSM states: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT.
- Detection in IDLE applies only when inst_valid_i is high. Priority: ecall > ebreak > mret > (irq_i & mstatus_i[3]).
- On ecall, ebreak or interrupt in IDLE:
  - Latch epc = inst_addr_i. For an interrupt the instruction is not executed; for ecall the software advances mepc.
  - Latch cause: 11 for ecall, 3 for ebreak, IRQ_CAUSE for the interrupt.
  - Go to W_MEPC.
- W_MEPC: write mepc = latched epc.
- W_MSTATUS: write mstatus_i with MPIE(bit7) = MIE(bit3), MIE = 0; all other bits unchanged.
- W_MCAUSE: write mcause = latched cause, then go to ASSERT with target = {mtvec_i[31:2], 2'b00}.
- mret in IDLE: go to W_MRET, which writes mstatus with MIE = MPIE, MPIE = 1; then go to ASSERT with target = mepc_i.
- ASSERT: int_assert_o = 1 and int_addr_o = target, then return to IDLE.
- csr_we_o is high exactly in the W_* states. Outputs are decoded from the registered state and latched data, so they are glitch-free.
- stall_o = (state != IDLE) | trap_or_mret_detected. The combinational term in IDLE keeps the trapping instruction from writing back. While stall_o is high, exu_we_i is low, so the CSR file's exu-over-clint write priority never fires.
- irq_i arriving mid-sequence is ignored until IDLE. After a trap MIE = 0, so a held irq_i cannot retrigger.

## Timing
- Trap detected in cycle T:
  - csr writes at T+1 (mepc), T+2 (mstatus), T+3 (mcause).
  - int_assert_o at T+4.
  - stall_o high T..T+4.
  - IDLE again at T+5.
- mret detected in cycle T: mstatus write at T+1, int_assert_o at T+2, stall_o high T..T+2.
- Each write lands in the CSR file on the edge ending its cycle. mstatus_i is therefore already updated when read in the following state.
- Reset values: state = IDLE; all outputs 0 (stall_o 0 while inputs are idle); latched epc, cause and target = 0.
- Reset asserted mid-sequence: return to IDLE immediately; no partial sequence is resumed; CSR writes already performed persist.

## Configuration
- CLINT_VECTORED_EN defined: if mtvec_i[1:0] == 2'b01 and the cause is an interrupt, target = {mtvec_i[31:2], 2'b00} + 4 × cause[30:0]. Synchronous traps always use the base.
- CLINT_VECTORED_EN undefined: mtvec_i[1:0] is ignored and every trap targets the base.

## Structure
- CSR addresses (`CSR_MEPC`, `CSR_MSTATUS`, `CSR_MCAUSE`) come from the shared defines file.
- Add to the shared package: the state enum; cause constants (CAUSE_ECALL_M = 11, CAUSE_BREAKPOINT = 3); mstatus bit positions (MSTATUS_MIE = 3, MSTATUS_MPIE = 7).
- Single module, no sub-module: an FSM plus small datapath registers.

## Test plan
- ecall at inst_addr 0x100, mtvec = 0x200, mstatus = 0x8:
  - T+1: mepc ← 0x100.
  - T+2: mstatus ← 0x80.
  - T+3: mcause ← 11.
  - T+4: int_assert_o = 1, int_addr_o = 0x200.
  - stall_o high 5 cycles.
- irq_i high with mstatus = 0x0 → no action. Set mstatus = 0x8 → trap with mcause = 0x8000000B and mepc = PC of the current valid instruction.
- mret with mstatus = 0x80 and mepc = 0x104 → T+1: mstatus ← 0x88; T+2: int_addr_o = 0x104.
- ecall and irq in the same cycle → mcause = 11. After the handler's mret, the still-held irq is taken.
- With CLINT_VECTORED_EN, mtvec = 0x201 and irq → int_addr_o = 0x22C. Without the macro → 0x200.
- rst_n pulsed low during W_MSTATUS → all outputs 0 at once. mcause is unwritten; mepc holds the new value.
